uart_rx_frac_cfg: RTL and testbench

UART_RX_FRAC_CFG -- requirements
Module: uart_rx_frac_cfg

---
 rtl/uart_rx_frac_cfg.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_frac_cfg.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frac_cfg.sv
// UART receiver with a fractional (DIV_NUM/DIV_DEN) bit-period phase accumulator.
// Optional parity support is compiled in when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_rx_frac_cfg #(
  parameter int DIV_NUM   = 25,
  parameter int DIV_DEN   = 1,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rx,
  input  logic [1:0]           parity_mode,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 break_det,
  output logic                 busy
);

  // state   | meaning
  // IDLE    | line idle, waiting for rx_s low
  // START   | timing to mid start bit, confirm or reject
  // DATA    | sampling DATA_BITS data bits, LSB first
  // PARITY  | sampling the parity bit (parity builds only)
  // STOP    | sampling STOP_BITS stop bits, reporting the frame
  // WAIT_HI | frame error seen, waiting for the line to go high
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd3;
  localparam logic [2:0] S_WAIT_HI = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY  = 3'd5;
`endif

  localparam int AW = $clog2(DIV_NUM + DIV_DEN + 1);
  localparam logic [AW-1:0] L_NUM  = AW'(DIV_NUM);
  localparam logic [AW-1:0] L_DEN  = AW'(DIV_DEN);
  localparam logic [AW-1:0] L_HALF = AW'(DIV_NUM / 2);
  localparam logic [3:0] L_LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] L_LAST_STOP = 4'(STOP_BITS - 1);

  logic                 r_meta;
  logic                 r_rx_s;
  logic [2:0]           r_state;
  logic [AW-1:0]        r_acc;
  logic [3:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_ferr;
  logic                 r_all0;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_en;
  logic                 r_par_odd;
  logic                 r_par;
  logic                 r_perr;
`else
  logic                 w_unused_parity_mode;
  assign w_unused_parity_mode = ^parity_mode;
`endif

  logic [AW-1:0] w_nxt;
  logic          w_tick;
  logic [AW-1:0] w_acc_step;
  logic          w_stop_ferr;

  assign w_nxt       = r_acc + L_DEN;
  assign w_tick      = (w_nxt >= L_NUM);
  assign w_acc_step  = w_tick ? (w_nxt - L_NUM) : w_nxt;
  assign w_stop_ferr = r_ferr | ~r_rx_s;
  assign busy        = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_meta <= 1'b1;
      r_rx_s <= 1'b1;
    end else begin
      r_meta <= rx;
      r_rx_s <= r_meta;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_ferr     <= 1'b0;
      r_all0     <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      break_det  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_par      <= 1'b0;
      r_perr     <= 1'b0;
`endif
    end else begin
      // status flags exist only alongside the valid pulse
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      break_det  <= 1'b0;
      if (r_state != S_IDLE) r_acc <= w_acc_step;
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state <= S_START;
            r_acc   <= '0;
            r_bit   <= '0;
            r_ferr  <= 1'b0;
            r_all0  <= 1'b1;
`ifdef UART_RX_PARITY_EN
            r_par_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
            r_par_odd <= (parity_mode == 2'b10);
            r_par     <= 1'b0;
            r_perr    <= 1'b0;
`endif
          end
        end
        S_START: begin
          if (w_nxt >= L_HALF) begin
            r_acc   <= '0;
            r_state <= r_rx_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            r_all0  <= r_all0 & ~r_rx_s;
`ifdef UART_RX_PARITY_EN
            r_par   <= r_par ^ r_rx_s;
`endif
            if (r_bit == L_LAST_DATA) begin
              r_bit <= '0;
`ifdef UART_RX_PARITY_EN
              r_state <= r_par_en ? S_PARITY : S_STOP;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_bit <= r_bit + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            r_perr  <= r_par_odd ? ~(r_par ^ r_rx_s) : (r_par ^ r_rx_s);
            r_all0  <= r_all0 & ~r_rx_s;
            r_state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (w_tick) begin
            r_ferr <= w_stop_ferr;
            if (r_bit == L_LAST_STOP) begin
              data      <= r_shift;
              valid     <= 1'b1;
              frame_err <= w_stop_ferr;
              break_det <= r_all0 & ~r_rx_s;
`ifdef UART_RX_PARITY_EN
              parity_err <= r_perr;
`endif
              r_acc   <= '0;
              r_state <= w_stop_ferr ? S_WAIT_HI : S_IDLE;
            end else begin
              r_all0 <= r_all0 & ~r_rx_s;
              r_bit  <= r_bit + 4'd1;
            end
          end
        end
        S_WAIT_HI: begin
          if (r_rx_s) begin
            r_acc   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frac_cfg.sv
// Directed bench: one receiver at 25 clk/bit, one at 13.5 clk/bit.
`timescale 1ns/1ps
module tb_uart_rx_frac_cfg;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  logic [1:0] pm_a = 2'b00;
  logic [1:0] pm_b = 2'b00;
  logic [7:0] data_a, data_b;
  logic valid_a, fe_a, pe_a, bk_a, busy_a;
  logic valid_b, fe_b, pe_b, bk_b, busy_b;

  always #5 clk = ~clk;

  uart_rx_frac_cfg #(.DIV_NUM(25), .DIV_DEN(1), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
    .clk(clk), .resetn(resetn), .rx(rx_a), .parity_mode(pm_a), .data(data_a),
    .valid(valid_a), .frame_err(fe_a), .parity_err(pe_a), .break_det(bk_a), .busy(busy_a));

  uart_rx_frac_cfg #(.DIV_NUM(27), .DIV_DEN(2), .DATA_BITS(8), .STOP_BITS(1)) dut_b (
    .clk(clk), .resetn(resetn), .rx(rx_b), .parity_mode(pm_b), .data(data_b),
    .valid(valid_b), .frame_err(fe_b), .parity_err(pe_b), .break_det(bk_b), .busy(busy_b));

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // valid-pulse history, captured mid-cycle
  int vcnt_a = 0;
  int vcnt_b = 0;
  logic [7:0] hd_a[32];
  logic       hfe_a[32], hpe_a[32], hbk_a[32];
  logic [7:0] hd_b[32];
  logic       herr_b[32];
  logic       leak = 1'b0;

  always @(negedge clk) begin
    if (valid_a) begin
      hd_a[vcnt_a % 32]  <= data_a;
      hfe_a[vcnt_a % 32] <= fe_a;
      hpe_a[vcnt_a % 32] <= pe_a;
      hbk_a[vcnt_a % 32] <= bk_a;
      vcnt_a <= vcnt_a + 1;
    end
    if (valid_b) begin
      hd_b[vcnt_b % 32]   <= data_b;
      herr_b[vcnt_b % 32] <= fe_b | pe_b | bk_b;
      vcnt_b <= vcnt_b + 1;
    end
    if ((!valid_a && (fe_a | pe_a | bk_a)) || (!valid_b && (fe_b | pe_b | bk_b)))
      leak <= 1'b1;
  end

  task automatic tx_bit_a(input logic v);
    rx_a = v;
    repeat (25) @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] d, input logic par_on, input logic par_bit);
    tx_bit_a(1'b0);
    for (int i = 0; i < 8; i++) tx_bit_a(d[i]);
    if (par_on) tx_bit_a(par_bit);
    tx_bit_a(1'b1);
  endtask

  // 13.5-cycle bits: bit k spans floor(k*27/2) .. floor((k+1)*27/2)
  int ph_b = 0;
  int pos_b = 0;
  task automatic tx_bit_b(input logic v);
    int n;
    rx_b = v;
    ph_b = ph_b + 27;
    n = ph_b / 2 - pos_b;
    pos_b = ph_b / 2;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_b(input logic [7:0] d);
    tx_bit_b(1'b0);
    for (int i = 0; i < 8; i++) tx_bit_b(d[i]);
    tx_bit_b(1'b1);
  endtask

  initial begin
    int v0;
    int lat;
    int n;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", data_a, 8'h00);
    chk("rst_valid", valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_errs", {fe_a, pe_a, bk_a}, 0);
    resetn = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // 0xA5, 8N1, latency from the falling edge
    v0 = vcnt_a;
    lat = 0;
    fork
      send_a(8'hA5, 1'b0, 1'b0);
      begin
        while (lat < 400 && !valid_a) begin
          @(posedge clk);
          #1;
          lat++;
        end
      end
    join
    $display("a5 latency %0d cycles", lat);
    chk("a5_latency_window", int'(lat >= 237 && lat <= 241), 1);
    repeat (30) @(posedge clk);
    #1;
    chk("a5_count", vcnt_a - v0, 1);
    chk("a5_data", hd_a[v0 % 32], 8'hA5);
    chk("a5_errs", {hfe_a[v0 % 32], hpe_a[v0 % 32], hbk_a[v0 % 32]}, 0);

    // fractional divider, back-to-back frames
    v0 = vcnt_b;
    ph_b = 0;
    pos_b = 0;
    send_b(8'h55);
    send_b(8'hAA);
    repeat (30) @(posedge clk);
    #1;
    chk("frac_count", vcnt_b - v0, 2);
    chk("frac_data0", hd_b[v0 % 32], 8'h55);
    chk("frac_data1", hd_b[(v0 + 1) % 32], 8'hAA);
    chk("frac_errs", {herr_b[v0 % 32], herr_b[(v0 + 1) % 32]}, 0);

    // 5-cycle glitch must be rejected as a false start
    v0 = vcnt_a;
    rx_a = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("glitch_busy_on", busy_a, 1);
    rx_a = 1'b1;
    n = 0;
    while (busy_a && n < 15) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("glitch_busy_off", busy_a, 0);
    repeat (300) @(posedge clk);
    #1;
    chk("glitch_no_valid", vcnt_a - v0, 0);

`ifdef UART_RX_PARITY_EN
    // odd parity, wrong parity bit, mode changed mid-frame
    v0 = vcnt_a;
    pm_a = 2'b10;
    fork
      send_a(8'h03, 1'b1, 1'b0);
      begin
        repeat (100) @(posedge clk);
        #1;
        pm_a = 2'b00;
      end
    join
    repeat (30) @(posedge clk);
    #1;
    chk("odd_count", vcnt_a - v0, 1);
    chk("odd_data", hd_a[v0 % 32], 8'h03);
    chk("odd_perr", hpe_a[v0 % 32], 1);
    chk("odd_ferr", hfe_a[v0 % 32], 0);
    v0 = vcnt_a;
    pm_a = 2'b01;
    send_a(8'h07, 1'b1, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    chk("even_count", vcnt_a - v0, 1);
    chk("even_data", hd_a[v0 % 32], 8'h07);
    chk("even_errs", {hfe_a[v0 % 32], hpe_a[v0 % 32]}, 0);
    pm_a = 2'b00;
`else
    // parity_mode is ignored: no parity bit expected
    v0 = vcnt_a;
    pm_a = 2'b10;
    send_a(8'h03, 1'b0, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    chk("nopar_count", vcnt_a - v0, 1);
    chk("nopar_data", hd_a[v0 % 32], 8'h03);
    chk("nopar_errs", {hfe_a[v0 % 32], hpe_a[v0 % 32]}, 0);
    pm_a = 2'b00;
`endif

    // break: 12 bit times low, then a clean 0x7E
    v0 = vcnt_a;
    rx_a = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("break_single_valid", vcnt_a - v0, 1);
    rx_a = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    send_a(8'h7E, 1'b0, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    chk("break_count", vcnt_a - v0, 2);
    chk("break_data", hd_a[v0 % 32], 8'h00);
    chk("break_ferr", hfe_a[v0 % 32], 1);
    chk("break_det", hbk_a[v0 % 32], 1);
    chk("after_break_data", hd_a[(v0 + 1) % 32], 8'h7E);
    chk("after_break_errs", {hfe_a[(v0 + 1) % 32], hpe_a[(v0 + 1) % 32], hbk_a[(v0 + 1) % 32]}, 0);

    // reset during data bit 4 of 0x5A
    v0 = vcnt_a;
    tx_bit_a(1'b0);
    tx_bit_a(1'b0);
    tx_bit_a(1'b1);
    tx_bit_a(1'b0);
    tx_bit_a(1'b1);
    rx_a = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_data", data_a, 8'h00);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_flags", {valid_a, fe_a, pe_a, bk_a}, 0);
    resetn = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("midrst_no_valid", vcnt_a - v0, 0);
    send_a(8'h3C, 1'b0, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    chk("post_rst_count", vcnt_a - v0, 1);
    chk("post_rst_data", hd_a[v0 % 32], 8'h3C);
    chk("post_rst_errs", {hfe_a[v0 % 32], hpe_a[v0 % 32], hbk_a[v0 % 32]}, 0);
    chk("data_hold", data_a, 8'h3C);

    chk("err_only_with_valid", leak, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
